// File: rtl/bm_pkg.sv
// Shared bin-manager types: widths, level-table entry layout and FSM state
// encoding for find_global_bkt_lvl.
`default_nettype none

package bm_pkg;

  localparam int WIDTH_BIN_ID = 10;
  localparam int WIDTH_LVL    = 16;

  localparam logic [WIDTH_BIN_ID-1:0] NO_BIN = '0;

  typedef enum logic [1:0] {
    FGB_IDLE  = 2'd0,
    FGB_READ  = 2'd1,
    FGB_CHECK = 2'd2,
    FGB_DONE  = 2'd3
  } fgb_state_e;

  typedef struct packed {
    logic                    valid;
    logic [WIDTH_BIN_ID-1:0] bin_id;
  } lvl_entry_t;

endpackage

`default_nettype wire

// File: rtl/find_global_bkt_lvl.sv
// ---------------------------------------------------------------------------
// find_global_bkt_lvl : scans the global level table downward from the local
// backtrack level to the nearest live level. Option: FIND_STATS_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module find_global_bkt_lvl
  import bm_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_find_i,
  output logic                    done_find_o,
  input  logic [WIDTH_LVL-1:0]    bkt_lvl_req_i,
  output logic                    lvl_rd_en_o,
  output logic [WIDTH_LVL-1:0]    lvl_rd_addr_o,
  input  logic [WIDTH_BIN_ID:0]   lvl_rd_data_i,
  output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
  output logic [WIDTH_BIN_ID-1:0] bkt_bin_o
`ifdef FIND_STATS_EN
  ,
  output logic [WIDTH_LVL-1:0]    scan_cnt_o
`endif
);

  localparam logic [WIDTH_LVL-1:0] LVL_ONE = WIDTH_LVL'(1);

  fgb_state_e              state_q, state_d;
  logic [WIDTH_LVL-1:0]    scan_q, scan_d;
  logic [WIDTH_LVL-1:0]    lvl_q, lvl_d;
  logic [WIDTH_BIN_ID-1:0] bin_q, bin_d;
  lvl_entry_t              rd_entry;

  assign rd_entry = lvl_rd_data_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FGB_IDLE;
      scan_q  <= '0;
      lvl_q   <= '0;
      bin_q   <= NO_BIN;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      lvl_q   <= lvl_d;
      bin_q   <= bin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    lvl_d   = lvl_q;
    bin_d   = bin_q;
    case (state_q)
      FGB_IDLE: begin
        if (start_find_i) begin
          if (bkt_lvl_req_i == '0) begin
            lvl_d   = '0;
            bin_d   = NO_BIN;
            state_d = FGB_DONE;
          end else begin
            scan_d  = bkt_lvl_req_i;
            state_d = FGB_READ;
          end
        end
      end
      FGB_READ: state_d = FGB_CHECK;
      FGB_CHECK: begin
        // Level 0 is never a candidate, so a miss at level 1 ends the scan.
        if (rd_entry.valid) begin
          lvl_d   = scan_q;
          bin_d   = rd_entry.bin_id;
          state_d = FGB_DONE;
        end else if (scan_q > LVL_ONE) begin
          scan_d  = scan_q - LVL_ONE;
          state_d = FGB_READ;
        end else begin
          lvl_d   = '0;
          bin_d   = NO_BIN;
          state_d = FGB_DONE;
        end
      end
      FGB_DONE: state_d = FGB_IDLE;
      default:  state_d = FGB_IDLE;
    endcase
  end

  always_comb begin
    done_find_o   = (state_q == FGB_DONE);
    lvl_rd_en_o   = (state_q == FGB_READ);
    lvl_rd_addr_o = (state_q == FGB_READ) ? scan_q : '0;
  end

  assign bkt_lvl_o = lvl_q;
  assign bkt_bin_o = bin_q;

`ifdef FIND_STATS_EN
  logic [WIDTH_LVL-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == FGB_IDLE) && start_find_i) begin
      cnt_d = '0;
    end else if ((state_q == FGB_CHECK) && (cnt_q != '1)) begin
      cnt_d = cnt_q + LVL_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign scan_cnt_o = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_find_global_bkt_lvl.sv
// Directed self-checking bench for find_global_bkt_lvl with a behavioural
// one-cycle-latency level table.
`default_nettype none

module tb_find_global_bkt_lvl;
  import bm_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    start_find_i;
  logic                    done_find_o;
  logic [WIDTH_LVL-1:0]    bkt_lvl_req_i;
  logic                    lvl_rd_en_o;
  logic [WIDTH_LVL-1:0]    lvl_rd_addr_o;
  logic [WIDTH_BIN_ID:0]   lvl_rd_data_i;
  logic [WIDTH_LVL-1:0]    bkt_lvl_o;
  logic [WIDTH_BIN_ID-1:0] bkt_bin_o;
`ifdef FIND_STATS_EN
  logic [WIDTH_LVL-1:0]    scan_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  logic [WIDTH_BIN_ID:0] tbl [0:15];
  logic [WIDTH_LVL-1:0]  rd_log [$];

  find_global_bkt_lvl dut (
    .clk           (clk),
    .rst           (rst),
    .start_find_i  (start_find_i),
    .done_find_o   (done_find_o),
    .bkt_lvl_req_i (bkt_lvl_req_i),
    .lvl_rd_en_o   (lvl_rd_en_o),
    .lvl_rd_addr_o (lvl_rd_addr_o),
    .lvl_rd_data_i (lvl_rd_data_i),
    .bkt_lvl_o     (bkt_lvl_o),
    .bkt_bin_o     (bkt_bin_o)
`ifdef FIND_STATS_EN
    ,
    .scan_cnt_o    (scan_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table returns the entry one cycle after the read; idle cycles present a
  // valid-looking junk word so a mistimed sample shows up as a wrong result.
  always @(posedge clk) begin
    if (lvl_rd_en_o) begin
      lvl_rd_data_i <= tbl[lvl_rd_addr_o[3:0]];
      rd_log.push_back(lvl_rd_addr_o);
    end else begin
      lvl_rd_data_i <= {1'b1, 10'h3FF};
    end
    if (done_find_o) n_done <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    tbl[0] = {1'b1, 10'd7};
  endtask

  // Issue a start at the current negedge (cycle 0) and wait for done.
  task automatic search(input string tag, input logic [15:0] req, input int exp_cyc,
                        input logic [15:0] exp_lvl, input logic [9:0] exp_bin,
                        input int exp_reads);
    int cyc;
    bit seen;
    rd_log.delete();
    start_find_i  = 1'b1;
    bkt_lvl_req_i = req;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start_find_i  = 1'b0;
      bkt_lvl_req_i = '0;
      if (done_find_o) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_done_cycle"}, cyc, exp_cyc);
    chk({tag, "_lvl"}, 32'(bkt_lvl_o), 32'(exp_lvl));
    chk({tag, "_bin"}, 32'(bkt_bin_o), 32'(exp_bin));
    chk({tag, "_nreads"}, rd_log.size(), exp_reads);
    for (int i = 0; i < rd_log.size(); i++)
      chk({tag, "_rd_addr"}, 32'(rd_log[i]), 32'(req) - i);
`ifdef FIND_STATS_EN
    chk({tag, "_scan_cnt"}, 32'(scan_cnt_o), exp_reads);
`endif
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(done_find_o), 32'd0);
  endtask

  initial begin
    int d0;
    rst           = 1'b0;
    start_find_i  = 1'b0;
    bkt_lvl_req_i = '0;
    clear_tbl();
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done_find_o), 32'd0);
    chk("rst_rd_en", 32'(lvl_rd_en_o), 32'd0);
    chk("rst_rd_addr", 32'(lvl_rd_addr_o), 32'd0);
    chk("rst_lvl", 32'(bkt_lvl_o), 32'd0);
    chk("rst_bin", 32'(bkt_bin_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    search("zero_req", 16'd0, 1, 16'd0, 10'd0, 0);

    tbl[5] = {1'b1, 10'd3};
    search("hit", 16'd5, 3, 16'd5, 10'd3, 1);

    clear_tbl();
    tbl[3] = {1'b1, 10'd2};
    search("miss2", 16'd5, 7, 16'd3, 10'd2, 3);

    clear_tbl();
    search("all_miss", 16'd4, 9, 16'd0, 10'd0, 4);

    clear_tbl();
    tbl[6] = {1'b1, 10'd0};
    tbl[8] = {1'b1, 10'd21};
    search("valid_bin0", 16'd8, 3, 16'd8, 10'd21, 1);
    search("valid_bin0b", 16'd6, 3, 16'd6, 10'd0, 1);

    // Earlier result must stay visible while a new search runs.
    clear_tbl();
    tbl[3] = {1'b1, 10'd2};
    tbl[2] = {1'b1, 10'd9};
    tbl[5] = {1'b1, 10'd11};
    search("seed", 16'd5, 3, 16'd5, 10'd11, 1);
    tbl[5] = '0;
    d0 = n_done;
    start_find_i  = 1'b1;
    bkt_lvl_req_i = 16'd5;
    @(negedge clk);
    start_find_i  = 1'b0;
    chk("hold_lvl", 32'(bkt_lvl_o), 32'd5);
    chk("hold_bin", 32'(bkt_bin_o), 32'd11);
    @(negedge clk);
    start_find_i  = 1'b1;
    bkt_lvl_req_i = 16'd2;
    @(negedge clk);
    start_find_i  = 1'b0;
    bkt_lvl_req_i = '0;
    repeat (12) @(negedge clk);
    chk("ignore_ndone", n_done - d0, 1);
    chk("ignore_lvl", 32'(bkt_lvl_o), 32'd3);
    chk("ignore_bin", 32'(bkt_bin_o), 32'd2);

    // Asynchronous reset during CHECK.
    d0 = n_done;
    start_find_i  = 1'b1;
    bkt_lvl_req_i = 16'd5;
    @(negedge clk);
    start_find_i  = 1'b0;
    bkt_lvl_req_i = '0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_lvl", 32'(bkt_lvl_o), 32'd0);
    chk("arst_bin", 32'(bkt_bin_o), 32'd0);
    chk("arst_rd_en", 32'(lvl_rd_en_o), 32'd0);
    repeat (4) @(negedge clk);
    chk("arst_no_done", n_done - d0, 0);
    rst = 1'b1;
    @(negedge clk);
    search("after_rst", 16'd5, 7, 16'd3, 10'd2, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
